// File: rtl/mem_port_arbiter_if.sv
// Bundle between the two MEM-stage lanes, the arbiter and the dcache request port.
// Signal suffixes are taken from the arbiter's side: the slave modport is the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                       flush_i;
  logic [1:0]                 lane_req_valid_i;
  logic [1:0]                 lane_req_we_i;
  logic [1:0][3:0]            lane_req_sel_i;
  logic [1:0][ADDR_WIDTH-1:0] lane_req_addr_i;
  logic [1:0][DATA_WIDTH-1:0] lane_req_data_i;
  logic [1:0]                 lane_req_uncache_i;
  logic [1:0][2:0]            lane_req_rd_type_i;
  logic [1:0]                 lane_req_ready_o;
  logic [1:0]                 lane_resp_valid_o;
  logic [DATA_WIDTH-1:0]      lane_resp_data_o;
  logic                       cache_req_valid_o;
  logic                       cache_req_we_o;
  logic [3:0]                 cache_req_sel_o;
  logic [ADDR_WIDTH-1:0]      cache_req_addr_o;
  logic [DATA_WIDTH-1:0]      cache_req_data_o;
  logic                       cache_req_uncache_o;
  logic [2:0]                 cache_req_rd_type_o;
  logic                       cache_req_ready_i;
  logic                       cache_resp_valid_i;
  logic [DATA_WIDTH-1:0]      cache_resp_data_i;
  logic [CNT_WIDTH-1:0]       conflict_cnt_o;

  modport slave (
    input  flush_i, lane_req_valid_i, lane_req_we_i, lane_req_sel_i, lane_req_addr_i,
           lane_req_data_i, lane_req_uncache_i, lane_req_rd_type_i,
           cache_req_ready_i, cache_resp_valid_i, cache_resp_data_i,
    output lane_req_ready_o, lane_resp_valid_o, lane_resp_data_o,
           cache_req_valid_o, cache_req_we_o, cache_req_sel_o, cache_req_addr_o,
           cache_req_data_o, cache_req_uncache_o, cache_req_rd_type_o, conflict_cnt_o
  );

  modport master (
    output flush_i, lane_req_valid_i, lane_req_we_i, lane_req_sel_i, lane_req_addr_i,
           lane_req_data_i, lane_req_uncache_i, lane_req_rd_type_i,
           cache_req_ready_i, cache_resp_valid_i, cache_resp_data_i,
    input  lane_req_ready_o, lane_resp_valid_o, lane_resp_data_o,
           cache_req_valid_o, cache_req_we_o, cache_req_sel_o, cache_req_addr_o,
           cache_req_data_o, cache_req_uncache_o, cache_req_rd_type_o, conflict_cnt_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single dcache request port between two MEM lanes (lane 0 older, fixed priority),
// keeps one request in flight, routes the response to its owner and honours pipeline flush.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t                state_q, state_d;
  logic                  owner_q;
  logic                  we_q;
  logic [3:0]            sel_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  uncache_q;
  logic [2:0]            rd_type_q;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  grant;
  logic                  gnt_lane;
  logic [1:0]            ready;
  logic [1:0]            resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    gnt_lane   = 1'b0;
    ready      = '0;
    resp_valid = '0;
    resp_data  = '0;
    unique case (state_q)
      IDLE: begin
        if (!bus.flush_i) begin
          ready[0] = bus.lane_req_valid_i[0];
          ready[1] = bus.lane_req_valid_i[1] & ~bus.lane_req_valid_i[0];
          if (|bus.lane_req_valid_i) begin
            grant    = 1'b1;
            gnt_lane = ~bus.lane_req_valid_i[0];
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        if (bus.cache_req_ready_i) state_d = bus.flush_i ? DROP : WAIT;
        else if (bus.flush_i)      state_d = IDLE;
      end
      WAIT: begin
        resp_data = bus.cache_resp_data_i;
        if (bus.cache_resp_valid_i && !bus.flush_i) resp_valid[owner_q] = 1'b1;
        if (bus.cache_resp_valid_i) state_d = IDLE;
        else if (bus.flush_i)       state_d = DROP;
      end
      DROP: begin
        if (bus.cache_resp_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A lane-1 stall counts only when not flushing; the counter sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.lane_req_valid_i[1] && !ready[1] && !bus.flush_i && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      uncache_q <= 1'b0;
      rd_type_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        owner_q   <= gnt_lane;
        we_q      <= bus.lane_req_we_i[gnt_lane];
        sel_q     <= bus.lane_req_sel_i[gnt_lane];
        addr_q    <= bus.lane_req_addr_i[gnt_lane];
        data_q    <= bus.lane_req_data_i[gnt_lane];
        uncache_q <= bus.lane_req_uncache_i[gnt_lane];
        rd_type_q <= bus.lane_req_rd_type_i[gnt_lane];
      end
    end
  end

  assign bus.lane_req_ready_o    = ready;
  assign bus.lane_resp_valid_o   = resp_valid;
  assign bus.lane_resp_data_o    = resp_data;
  assign bus.cache_req_valid_o   = (state_q == REQ);
  assign bus.cache_req_we_o      = we_q;
  assign bus.cache_req_sel_o     = sel_q;
  assign bus.cache_req_addr_o    = addr_q;
  assign bus.cache_req_data_o    = data_q;
  assign bus.cache_req_uncache_o = uncache_q;
  assign bus.cache_req_rd_type_o = rd_type_q;
  assign bus.conflict_cnt_o      = cnt_q;

endmodule
